// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared encodings for the LED pattern sequencer: the MODE request codes,
// the FSM state enum and the pattern each mode starts from on a load.
package led_seq_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BLINK  = 3'd1,
    ST_SCAN_L = 3'd2,
    ST_SCAN_R = 3'd3,
    ST_COUNT  = 3'd4
  } state_t;

  localparam logic [7:0] PAT_OFF   = 8'h00;
  localparam logic [7:0] PAT_BLINK = 8'hFF;
  localparam logic [7:0] PAT_SCAN  = 8'h01;
  localparam logic [7:0] PAT_COUNT = 8'h00;

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// step_prescaler
// Divides CLK down to a one-cycle step tick every DIV enabled cycles.
// Ports:
//   CLK   - system clock
//   RST   - synchronous reset, active-high; counter to 0
//   CLEAR - synchronous restart of the count (used on mode load)
//   HOLD  - freezes the count and suppresses the tick
//   TICK  - combinational, high on the edge where the count wraps
module step_prescaler #(
  parameter int DIV = 3000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLEAR,
  input  logic HOLD,
  output logic TICK
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign TICK = (cnt == CW'(DIV - 1)) && !HOLD;

  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      cnt <= '0;
    end else if (!HOLD) begin
      if (TICK) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Sole owner of the eight board LEDs. A prescaler paces pattern steps; the
// FSM below advances the selected pattern on each step.
// Ports:
//   CLK        - 12 MHz system clock
//   RST        - synchronous reset, active-high
//   MODE       - requested mode (OFF, BLINK, SCAN, COUNT)
//   MODE_VALID - one-cycle load strobe for MODE
//   PAUSE      - level; freezes prescaler and pattern
//   STEP       - registered one-cycle pulse after every pattern step
//   LED7..LED0 - registered pattern bits, LED7 is the MSB
//
// state     | meaning
// ST_OFF    | all LEDs dark, steps still pulse STEP
// ST_BLINK  | whole pattern inverts every step
// ST_SCAN_L | single lit bit moving toward LED7
// ST_SCAN_R | single lit bit moving toward LED0
// ST_COUNT  | pattern is an 8-bit binary up-counter
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DIV = 3000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] MODE,
  input  logic       MODE_VALID,
  input  logic       PAUSE,
  output logic       STEP,
  output logic       LED7,
  output logic       LED6,
  output logic       LED5,
  output logic       LED4,
  output logic       LED3,
  output logic       LED2,
  output logic       LED1,
  output logic       LED0
);

  state_t     state;
  logic [7:0] pattern;
  logic       tick;

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .CLEAR (MODE_VALID),
    .HOLD  (PAUSE),
    .TICK  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_OFF;
      pattern <= PAT_OFF;
      STEP    <= 1'b0;
    end else if (MODE_VALID) begin
      // A load wins over a coincident tick and restarts the step period.
      STEP <= 1'b0;
      case (MODE)
        MODE_BLINK: begin state <= ST_BLINK;  pattern <= PAT_BLINK; end
        MODE_SCAN:  begin state <= ST_SCAN_L; pattern <= PAT_SCAN;  end
        MODE_COUNT: begin state <= ST_COUNT;  pattern <= PAT_COUNT; end
        default:    begin state <= ST_OFF;    pattern <= PAT_OFF;   end
      endcase
    end else begin
      STEP <= tick;
      case (state)
        ST_OFF:   pattern <= PAT_OFF;
        ST_BLINK: if (tick) pattern <= ~pattern;
        ST_SCAN_L: if (tick) begin
          // Turn at the end so 0x80 is shown once and never shifted out.
          if (pattern == 8'h80) begin
            state   <= ST_SCAN_R;
            pattern <= 8'h40;
          end else begin
            pattern <= pattern << 1;
          end
        end
        ST_SCAN_R: if (tick) begin
          if (pattern == 8'h01) begin
            state   <= ST_SCAN_L;
            pattern <= 8'h02;
          end else begin
            pattern <= pattern >> 1;
          end
        end
        ST_COUNT: if (tick) pattern <= pattern + 8'd1;
        default: begin
          state   <= ST_OFF;
          pattern <= PAT_OFF;
        end
      endcase
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = pattern;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Directed test-plan sequences followed by random traffic, every cycle
// checked against a mode/step-count reference model.
module tb_led_pattern_sequencer;

  localparam int DIV = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] MODE;
  logic       MODE_VALID;
  logic       PAUSE;
  logic       STEP;
  logic       LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0;
  logic [7:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, steps taken since load, cycles into current step.
  int m_mode  = 0;
  int m_k     = 0;
  int m_ph    = 0;
  bit m_step  = 1'b0;

  always #5 CLK = ~CLK;

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  led_pattern_sequencer #(.DIV(DIV)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MODE       (MODE),
    .MODE_VALID (MODE_VALID),
    .PAUSE      (PAUSE),
    .STEP       (STEP),
    .LED7       (LED7),
    .LED6       (LED6),
    .LED5       (LED5),
    .LED4       (LED4),
    .LED3       (LED3),
    .LED2       (LED2),
    .LED1       (LED1),
    .LED0       (LED0)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pattern after k steps in a given mode, straight from the pattern rules.
  function automatic logic [7:0] exp_pat(input int md, input int k);
    int p, pos;
    case (md)
      1: return (k % 2 == 0) ? 8'hFF : 8'h00;
      2: begin
        p   = k % 14;
        pos = (p <= 7) ? p : 14 - p;
        return 8'(1 << pos);
      end
      3: return 8'(k % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [1:0] md, input bit p);
    bit tk;
    RST = r; MODE_VALID = v; MODE = md; PAUSE = p;
    @(posedge CLK);
    if (r) begin
      m_mode = 0; m_k = 0; m_ph = 0; m_step = 0;
    end else if (v) begin
      m_mode = int'(md); m_k = 0; m_ph = 0; m_step = 0;
    end else begin
      tk = (m_ph == DIV - 1) && !p;
      m_step = tk;
      if (tk) begin
        m_ph = 0;
        m_k++;
      end else if (!p) begin
        m_ph++;
      end
    end
    #1;
    check_eq("led", leds, exp_pat(m_mode, m_k));
    check_eq("step", {7'd0, STEP}, {7'd0, m_step});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; MODE = 2'd0; MODE_VALID = 1'b0; PAUSE = 1'b0;

    // 1: reset then idle in OFF
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("rst_led", leds, 8'h00);
    check_eq("rst_step", {7'd0, STEP}, 8'h00);
    idle(20);

    // 2: blink
    cyc(1'b0, 1'b1, 2'd1, 1'b0);
    check_eq("blink_load", leds, 8'hFF);
    idle(4);
    check_eq("blink_step1", leds, 8'h00);
    idle(4);
    check_eq("blink_step2", leds, 8'hFF);

    // 3: scan, 30 steps
    cyc(1'b0, 1'b1, 2'd2, 1'b0);
    check_eq("scan_load", leds, 8'h01);
    idle(7 * DIV);
    check_eq("scan_top", leds, 8'h80);
    idle(7 * DIV);
    check_eq("scan_bottom", leds, 8'h01);
    idle(16 * DIV);

    // 4: count through wrap
    cyc(1'b0, 1'b1, 2'd3, 1'b0);
    idle(255 * DIV);
    check_eq("cnt_255", leds, 8'hFF);
    idle(DIV);
    check_eq("cnt_wrap", leds, 8'h00);
    idle(DIV);
    check_eq("cnt_257", leds, 8'h01);

    // 5: pause one cycle after a step, release, then load during pause
    idle(1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'd0, 1'b1);
    idle(2);
    check_eq("pause_hold", {7'd0, STEP}, 8'h00);
    idle(1);
    check_eq("pause_resume", {7'd0, STEP}, 8'h01);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd1, 1'b1);
    check_eq("pause_load", leds, 8'hFF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 2'd0, 1'b1);
    idle(4);

    // 6: load on a tick edge, then reset mid-scan
    cyc(1'b0, 1'b1, 2'd3, 1'b0);
    idle(DIV - 1 + DIV);
    cyc(1'b0, 1'b1, 2'd2, 1'b0);
    check_eq("load_tick_led", leds, 8'h01);
    check_eq("load_tick_step", {7'd0, STEP}, 8'h00);
    idle(3 * DIV + 1);
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("mid_rst", leds, 8'h00);
    idle(12);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
          2'($urandom_range(0, 3)), $urandom_range(0, 99) < 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
